// File: rtl/somador_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | somador_serial : bit-serial N-bit adder, one full-adder cell + carry flop|
// | Optional subtract mode via macro SOMADOR_SERIAL_SUB_EN.       Rev 1.0    |
// +--------------------------------------------------------------------------+
module somador_serial #(
   parameter int N  = 8,
   parameter int CW = $clog2(N) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
`ifdef SOMADOR_SERIAL_SUB_EN
   input  logic         sub,
`endif
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] soma,
   output logic         cout
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      SOMANDO = 2'd1,
      PRONTO  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  reg_a_q, reg_a_d;
   logic [N-1:0]  reg_b_q, reg_b_d;
   logic [N-1:0]  res_q,   res_d;
   logic [N-1:0]  soma_q,  soma_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          carry_q, carry_d;
   logic          cout_q,  cout_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   logic [N-1:0]  b_load;
   logic          carry_load;
   logic          bit_s;
   logic          bit_c;

   // Subtraction is a + ~b + 1, so only the B operand and initial carry differ.
`ifdef SOMADOR_SERIAL_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   assign bit_s = reg_a_q[0] ^ reg_b_q[0] ^ carry_q;
   assign bit_c = (reg_a_q[0] & reg_b_q[0]) | (reg_a_q[0] & carry_q) | (reg_b_q[0] & carry_q);

   always_comb begin
      state_d = state_q;
      reg_a_d = reg_a_q;
      reg_b_d = reg_b_q;
      res_d   = res_q;
      soma_d  = soma_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         OCIOSO, PRONTO: begin
            state_d = OCIOSO;
            if (start) begin
               reg_a_d = a;
               reg_b_d = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = SOMANDO;
            end
         end
         SOMANDO: begin
            reg_a_d = reg_a_q >> 1;
            reg_b_d = reg_b_q >> 1;
            res_d   = {bit_s, res_q[N-1:1]};
            carry_d = bit_c;
            cnt_d   = cnt_q + CW'(1);
            // Final bit: publish the result including the bit computed this edge.
            if (cnt_q == CW'(N - 1)) begin
               soma_d  = {bit_s, res_q[N-1:1]};
               cout_d  = bit_c;
               state_d = PRONTO;
            end
         end
         default: state_d = OCIOSO;
      endcase

      busy_d = (state_d == SOMANDO);
      done_d = (state_d == PRONTO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCIOSO;
         reg_a_q <= '0;
         reg_b_q <= '0;
         res_q   <= '0;
         soma_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_a_q <= reg_a_d;
         reg_b_q <= reg_b_d;
         res_q   <= res_d;
         soma_q  <= soma_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign soma = soma_q;
   assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_somador_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_somador_serial : directed bench for somador_serial (N=8 and N=4).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_somador_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] soma8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       cin4 = 1'b0;
   logic       busy4, done4, cout4;
   logic [3:0] soma4;

`ifdef SOMADOR_SERIAL_SUB_EN
   logic       sub8 = 1'b0;
   logic       sub4 = 1'b0;
`endif

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   somador_serial #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
`ifdef SOMADOR_SERIAL_SUB_EN
      .sub   (sub8),
`endif
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .soma  (soma8),
      .cout  (cout8)
   );

   somador_serial #(.N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
`ifdef SOMADOR_SERIAL_SUB_EN
      .sub   (sub4),
`endif
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .busy  (busy4),
      .done  (done4),
      .soma  (soma4),
      .cout  (cout4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One full N=8 operation: busy for 8 cycles, then a single done cycle with the result.
   task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [7:0] es, input logic ec);
      logic [7:0] busy_seen;
      logic [7:0] done_seen;
      @(negedge clk);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      busy_seen = '0;
      done_seen = '0;
      for (int i = 0; i < 8; i++) begin
         busy_seen[i] = busy8;
         done_seen[i] = done8;
         @(negedge clk);
      end
      check({tag, "_busy8"}, 32'(busy_seen), 32'hFF);
      check({tag, "_nodone"}, 32'(done_seen), 32'h00);
      check({tag, "_done"}, 32'({done8, busy8}), 32'b10);
      check({tag, "_res"}, 32'({cout8, soma8}), 32'({ec, es}));
      @(negedge clk);
      check({tag, "_done_low"}, 32'({done8, busy8}), 32'b00);
   endtask

   initial begin
      int done_cnt;
      int done_idx;
      logic [8:0] cap;
      logic [4:0] exp4;

      // Reset state
      #2;
      check("rst_out8", 32'({busy8, done8, cout8, soma8}), 32'h0);
      check("rst_out4", 32'({busy4, done4, cout4, soma4}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
      op8("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

      // Start and operand changes while busy must be ignored.
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
      done_cnt = 0; done_idx = -1; cap = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (i == 2) begin a8 = 8'h12; b8 = 8'h34; start8 = 1'b1; end
         if (i == 4) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
         if (done8) begin
            done_cnt++;
            done_idx = i;
            cap = {cout8, soma8};
         end
      end
      cin8 = 1'b0;
      check("ign_done_cnt", 32'(done_cnt), 32'd1);
      check("ign_done_idx", 32'(done_idx), 32'd8);
      check("ign_res", 32'(cap), 32'h003);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_out", 32'({busy8, done8, cout8, soma8}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) done_cnt++;
      end
      check("mid_rst_quiet", 32'(done_cnt), 32'd0);
      op8("after_rst", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

      // N=4 exhaustive sweep, back-to-back starts accepted in PRONTO.
      @(negedge clk);
      {a4, b4, cin4} = 9'd0;
      start4 = 1'b1;
      for (int v = 0; v < 512; v++) begin
         repeat (5) @(negedge clk);
         exp4 = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
         check($sformatf("sweep4_%0d", v), 32'({done4, cout4, soma4}), 32'({1'b1, exp4}));
         if (v < 511) {a4, b4, cin4} = 9'(v + 1);
         else start4 = 1'b0;
      end
      @(negedge clk);
      check("sweep4_idle", 32'({done4, busy4}), 32'b00);

`ifdef SOMADOR_SERIAL_SUB_EN
      sub8 = 1'b1;
      op8("sub_5_7", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
      op8("sub_7_5", 8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
      sub8 = 1'b0;
      op8("sub0_add", 8'h07, 8'h05, 1'b1, 8'h0D, 1'b0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
